// File: rtl/mem_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | mem_ctrl_pkg : shared types, size codes and helpers for mem_ctrl          |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_FETCH = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [1:0]  SIZE_B      = 2'd0;
   localparam logic [1:0]  SIZE_H      = 2'd1;
   localparam logic [1:0]  SIZE_W      = 2'd2;
   localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

   // Size code 3 is undefined on the bus and is treated like a word.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      logic [2:0] n;
      case (size)
         SIZE_B:  n = 3'd1;
         SIZE_H:  n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
      logic [31:0] s;
      s = w >> {idx, 3'b000};
      return s[7:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl_byte_asm.sv
// +--------------------------------------------------------------------------+
// | mem_ctrl_byte_asm : collects little-endian load bytes, zero/sign-extends  |
// | Revision          : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_ctrl_byte_asm
   import mem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [1:0]  idx,
   input  logic [7:0]  din,
   input  logic [1:0]  size,
   input  logic        sign,
   output logic [31:0] value
);

   logic [3:0][7:0] bytes_q;
   logic [3:0][7:0] bytes_d;

   // The value already includes the byte arriving this cycle, so the final
   // byte can be registered by the caller on the same edge it is captured.
   always_comb begin
      bytes_d = bytes_q;
      if (we) begin
         bytes_d[idx] = din;
      end
      case (size)
         SIZE_B:  value = {{24{sign & bytes_d[0][7]}}, bytes_d[0]};
         SIZE_H:  value = {{16{sign & bytes_d[1][7]}}, bytes_d[1], bytes_d[0]};
         default: value = {bytes_d[3], bytes_d[2], bytes_d[1], bytes_d[0]};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bytes_q <= '0;
      end else begin
         bytes_q <= bytes_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// +--------------------------------------------------------------------------+
// | mem_ctrl : serialises loads/stores/fetches onto a byte-wide RAM/IO bus    |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned        ADDR_W  = 32,
   parameter logic [ADDR_W-1:0]  IO_BASE = ADDR_W'(IO_BASE_DEF)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rdy,
   input  logic              clr,
   input  logic              RN,
   input  logic              WN,
   input  logic [1:0]        Size,
   input  logic              Sign,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [31:0]       Wvalue,
   output logic              Mem_Success,
   output logic [31:0]       Read_Value,
   input  logic              IF_Req,
   input  logic [ADDR_W-1:0] IF_Addr,
   output logic              IF_Success,
   output logic [31:0]       IF_Inst,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [1:0]        size_q, size_d;
   logic              sign_q, sign_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] mem_a_q, mem_a_d;
   logic [7:0]        mem_dout_q, mem_dout_d;
   logic              mem_wr_q, mem_wr_d;
   logic              mem_success_q, mem_success_d;
   logic [31:0]       read_value_q, read_value_d;
   logic              if_success_q, if_success_d;
   logic [31:0]       if_inst_q, if_inst_d;

   logic              asm_we;
   logic [31:0]       asm_value;
   logic [2:0]        cnt_next;
   logic [2:0]        n_bytes;
   logic [ADDR_W-1:0] addr_next;

   function automatic logic is_io(input logic [ADDR_W-1:0] a);
      return a[17:16] == IO_BASE[17:16];
   endfunction

   mem_ctrl_byte_asm u_byte_asm (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (asm_we),
      .idx   (cnt_q[1:0]),
      .din   (mem_din),
      .size  (size_q),
      .sign  (sign_q),
      .value (asm_value)
   );

   assign cnt_next  = cnt_q + 3'd1;
   assign n_bytes   = size_bytes(size_q);
   assign addr_next = base_q + ADDR_W'(cnt_next);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      base_d        = base_q;
      size_d        = size_q;
      sign_d        = sign_q;
      wdata_d       = wdata_q;
      mem_a_d       = mem_a_q;
      mem_dout_d    = mem_dout_q;
      mem_wr_d      = mem_wr_q;
      mem_success_d = mem_success_q;
      read_value_d  = read_value_q;
      if_success_d  = if_success_q;
      if_inst_d     = if_inst_q;
      asm_we        = 1'b0;

      if (rdy) begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = 3'd0;
               if (WN || RN) begin
                  base_d  = Addr;
                  size_d  = Size;
                  sign_d  = Sign;
                  wdata_d = Wvalue;
                  mem_a_d = Addr;
                  if (WN) begin
                     state_d    = ST_WRITE;
                     mem_dout_d = Wvalue[7:0];
                     mem_wr_d   = !(is_io(Addr) && io_buffer_full);
                  end else begin
                     state_d = ST_READ;
                  end
               end else if (IF_Req && !clr) begin
                  state_d = ST_FETCH;
                  base_d  = IF_Addr;
                  size_d  = SIZE_W;
                  sign_d  = 1'b0;
                  mem_a_d = IF_Addr;
               end
            end

            ST_READ, ST_FETCH: begin
               if (state_q == ST_FETCH && clr) begin
                  state_d  = ST_IDLE;
                  mem_wr_d = 1'b0;
               end else begin
                  asm_we = 1'b1;
                  cnt_d  = cnt_next;
                  if (cnt_next == n_bytes) begin
                     state_d = ST_DONE;
                     if (state_q == ST_READ) begin
                        mem_success_d = 1'b1;
                        read_value_d  = asm_value;
                     end else begin
                        if_success_d = 1'b1;
                        if_inst_d    = asm_value;
                     end
                  end else begin
                     mem_a_d = addr_next;
                  end
               end
            end

            // A byte only counts as written once mem_wr was high for it;
            // a blocked byte is re-presented until the IO sink drains.
            ST_WRITE: begin
               if (mem_wr_q) begin
                  if (cnt_next == n_bytes) begin
                     state_d       = ST_DONE;
                     mem_wr_d      = 1'b0;
                     mem_success_d = 1'b1;
                  end else begin
                     cnt_d      = cnt_next;
                     mem_a_d    = addr_next;
                     mem_dout_d = byte_sel(wdata_q, cnt_next[1:0]);
                     mem_wr_d   = !(is_io(addr_next) && io_buffer_full);
                  end
               end else begin
                  mem_wr_d = !(is_io(mem_a_q) && io_buffer_full);
               end
            end

            ST_DONE: begin
               state_d       = ST_IDLE;
               mem_success_d = 1'b0;
               if_success_d  = 1'b0;
            end

            default: begin
               state_d  = ST_IDLE;
               mem_wr_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         base_q        <= '0;
         size_q        <= '0;
         sign_q        <= 1'b0;
         wdata_q       <= '0;
         mem_a_q       <= '0;
         mem_dout_q    <= '0;
         mem_wr_q      <= 1'b0;
         mem_success_q <= 1'b0;
         read_value_q  <= '0;
         if_success_q  <= 1'b0;
         if_inst_q     <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         base_q        <= base_d;
         size_q        <= size_d;
         sign_q        <= sign_d;
         wdata_q       <= wdata_d;
         mem_a_q       <= mem_a_d;
         mem_dout_q    <= mem_dout_d;
         mem_wr_q      <= mem_wr_d;
         mem_success_q <= mem_success_d;
         read_value_q  <= read_value_d;
         if_success_q  <= if_success_d;
         if_inst_q     <= if_inst_d;
      end
   end

   assign Mem_Success = mem_success_q;
   assign Read_Value  = read_value_q;
   assign IF_Success  = if_success_q;
   assign IF_Inst     = if_inst_q;
   assign mem_a       = mem_a_q;
   assign mem_dout    = mem_dout_q;
   assign mem_wr      = mem_wr_q;

endmodule

`default_nettype wire
